// File: rtl/mem_seq_if.sv
// Request/response bundle between a client and the mem_seq sequencer.
// The client drives requests through the master modport; the sequencer answers through the slave modport.
interface mem_seq_if #(
   parameter int AW = 5,
   parameter int DW = 8
);
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          done;
   logic [DW-1:0] rsp_rdata;
   logic          vfy_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, done, rsp_rdata, vfy_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, done, rsp_rdata, vfy_err
   );
endinterface

// File: rtl/mem_seq.sv
// mem_seq: sequences single-word reads/writes onto a strobed memory with a bidirectional data bus.
// Define MEM_SEQ_VERIFY_EN to add a read-back verify after every write (vfy_err on mismatch).
module mem_seq #(
   parameter int AW = 5,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   mem_seq_if.slave      bus,
   output logic [AW-1:0] mem_addr,
   inout  wire  [DW-1:0] mem_data,
   output logic          mem_read,
   output logic          mem_write
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WSETUP  = 3'd1;
   localparam logic [2:0] WSTROBE = 3'd2;
   localparam logic [2:0] WHOLD   = 3'd3;
   localparam logic [2:0] RSTROBE = 3'd4;
   localparam logic [2:0] RCAPT   = 3'd5;
`ifdef MEM_SEQ_VERIFY_EN
   localparam logic [2:0] VRD     = 3'd6;
   localparam logic [2:0] VCAP    = 3'd7;
`endif

   logic [2:0]    state_q, state_d;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [DW-1:0] rdata_q;
   logic          done_q, done_d;
   logic          read_q, read_d;
   logic          write_q, write_d;
   logic          drive_q, drive_d;
   logic          ready;
   logic          accept;

   assign ready  = (state_q == IDLE) && !rst;
   assign accept = bus.req_valid && ready;

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = bus.req_we ? WSETUP : RSTROBE;
            end
         end
         WSETUP:  state_d = WSTROBE;
         WSTROBE: state_d = WHOLD;
         WHOLD: begin
`ifdef MEM_SEQ_VERIFY_EN
            state_d = VRD;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
         end
         RSTROBE: state_d = RCAPT;
         RCAPT: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
`ifdef MEM_SEQ_VERIFY_EN
         VRD:  state_d = VCAP;
         VCAP: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   // Memory controls are registered from the next state so mem_write never glitches between states.
   always_comb begin
      write_d = (state_d == WSTROBE);
      drive_d = (state_d == WSETUP) || (state_d == WSTROBE) || (state_d == WHOLD);
`ifdef MEM_SEQ_VERIFY_EN
      read_d  = (state_d == RSTROBE) || (state_d == RCAPT) || (state_d == VRD) || (state_d == VCAP);
`else
      read_d  = (state_d == RSTROBE) || (state_d == RCAPT);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         done_q  <= 1'b0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         drive_q <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
         read_q  <= read_d;
         write_q <= write_d;
         drive_q <= drive_d;
         if (accept) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end
         if (state_q == RCAPT) begin
            rdata_q <= mem_data;
         end
      end
   end

`ifdef MEM_SEQ_VERIFY_EN
   logic vfy_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         vfy_err_q <= 1'b0;
      end else begin
         vfy_err_q <= (state_q == VCAP) && (mem_data != wdata_q);
      end
   end

   assign bus.vfy_err = vfy_err_q;
`else
   assign bus.vfy_err = 1'b0;
`endif

   assign bus.req_ready = ready;
   assign bus.done      = done_q;
   assign bus.rsp_rdata = rdata_q;

   assign mem_addr  = addr_q;
   assign mem_read  = read_q;
   assign mem_write = write_q;
   assign mem_data  = drive_q ? wdata_q : {DW{1'bz}};

   // The read enable and the bus drive are decoded from disjoint state sets.
   a_no_contention : assert property (@(posedge clk) !(read_q && drive_q));
   a_done_pulse    : assert property (@(posedge clk) done_q |-> (state_q == IDLE));
endmodule

// File: tb/tb_mem_seq.sv
// Scoreboard bench for mem_seq: randomized and directed accesses against a behavioural memory model.
// Build with MEM_SEQ_VERIFY_EN defined to exercise the write-verify path with a stuck-at read bit.
`timescale 1ns/1ps
module tb_mem_seq;
   localparam int AW = 5;
   localparam int DW = 8;
   localparam int NW = 1 << AW;
`ifdef MEM_SEQ_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_seq_if #(.AW(AW), .DW(DW)) bus();
   logic [AW-1:0] mem_addr;
   wire  [DW-1:0] mem_data;
   logic          mem_read;
   logic          mem_write;

   mem_seq #(.AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_read  (mem_read),
      .mem_write (mem_write)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] init_val(input int i);
      return DW'((i * 53) ^ 8'h5A);
   endfunction

   // Physical memory: captures on the rising edge of mem_write, optional stuck-at-0 on read bit 0.
   logic [DW-1:0] phys_mem [NW];
   logic          stuck0 = 1'b0;
   logic [DW-1:0] rd_drive;
   int            wr_edges = 0;

   assign rd_drive = phys_mem[mem_addr] & (stuck0 ? ~DW'(1) : {DW{1'b1}});
   assign mem_data = mem_read ? rd_drive : {DW{1'bz}};

   initial begin
      for (int i = 0; i < NW; i++) phys_mem[i] = init_val(i);
      forever begin
         @(posedge mem_write);
         phys_mem[mem_addr] = mem_data;
         wr_edges++;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Reference model and scoreboard.
   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp_rdata;
      logic          exp_vfy;
      int            lat;
      int            acc;
   } item_t;

   item_t         q[$];
   logic [DW-1:0] ref_mem [NW];
   logic [DW-1:0] last_rd = '0;

   function automatic logic [DW-1:0] read_back(input logic [DW-1:0] v);
      return stuck0 ? (v & ~DW'(1)) : v;
   endfunction

   function automatic void push_item(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      item_t it;
      it.we    = we;
      it.addr  = a;
      it.wdata = d;
      it.acc   = cyc + 1;
      if (we) begin
         ref_mem[a]   = d;
         it.exp_vfy   = VERIFY && (read_back(d) != d);
         it.exp_rdata = last_rd;
         it.lat       = VERIFY ? 5 : 3;
      end else begin
         last_rd      = read_back(ref_mem[a]);
         it.exp_vfy   = 1'b0;
         it.exp_rdata = last_rd;
         it.lat       = 2;
      end
      q.push_back(it);
   endfunction

   // Monitor: samples on the falling edge and retires one scoreboard entry per done pulse.
   int    wr_cyc = 0;
   int    rd_cyc = 0;
   int    n_txn  = 0;
   item_t mon_it;

   always @(negedge clk) begin
      if (rst) begin
         wr_cyc = 0;
         rd_cyc = 0;
      end else begin
         if (mem_write) begin
            wr_cyc++;
            if (q.size() > 0) begin
               chk("wr_bus_data", 32'(mem_data), 32'(q[0].wdata));
               chk("wr_addr", 32'(mem_addr), 32'(q[0].addr));
            end
         end
         if (mem_read) begin
            rd_cyc++;
            chk("rd_bus_undriven", 32'(mem_data), 32'(rd_drive));
            chk("rd_no_write", 32'(mem_write), 32'(0));
            if (q.size() > 0) chk("rd_addr", 32'(mem_addr), 32'(q[0].addr));
         end
         if (bus.done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 32'(bus.done), 32'(0));
            end else begin
               mon_it = q.pop_front();
               n_txn++;
               chk("latency", 32'(cyc - mon_it.acc), 32'(mon_it.lat));
               chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(mon_it.exp_rdata));
               chk("vfy_err", 32'(bus.vfy_err), 32'(mon_it.exp_vfy));
               chk("mem_write_cycles", 32'(wr_cyc), 32'(mon_it.we ? 1 : 0));
               chk("mem_read_cycles", 32'(rd_cyc), 32'(mon_it.we ? (VERIFY ? 2 : 0) : 2));
               $display("txn %0d: %s addr=%02h wdata=%02h rsp=%02h vfy=%0b lat=%0d",
                        n_txn, mon_it.we ? "WR" : "RD", mon_it.addr, mon_it.wdata,
                        bus.rsp_rdata, bus.vfy_err, cyc - mon_it.acc);
            end
            wr_cyc = 0;
            rd_cyc = 0;
         end else begin
            chk("vfy_err_without_done", 32'(bus.vfy_err), 32'(0));
         end
         chk("req_ready", 32'(bus.req_ready), 32'(!(q.size() > 0 && q[0].acc <= cyc)));
      end
   end

   // Driver helpers; all inputs change 1 ns after the rising edge.
   task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int t;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = a;
      bus.req_wdata = d;
      t = 0;
      while (!bus.req_ready && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (!bus.req_ready) begin
         chk("ready_timeout", 32'(bus.req_ready), 32'(1));
      end else begin
         push_item(we, a, d);
         @(posedge clk); #1;
      end
   endtask

   task automatic idle(input int n);
      bus.req_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      int t;
      bus.req_valid = 1'b0;
      t = 0;
      while (q.size() > 0 && t < 50) begin
         @(posedge clk); #1;
         t++;
      end
      chk("drain_pending", 32'(q.size()), 32'(0));
   endtask

   task automatic check_reset_vals();
      chk("rst_done", 32'(bus.done), 32'(0));
      chk("rst_vfy_err", 32'(bus.vfy_err), 32'(0));
      chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'(0));
      chk("rst_mem_read", 32'(mem_read), 32'(0));
      chk("rst_mem_write", 32'(mem_write), 32'(0));
      chk("rst_mem_addr", 32'(mem_addr), 32'(0));
      chk("rst_req_ready", 32'(bus.req_ready), 32'(0));
   endtask

   initial begin
      logic [DW-1:0] saved;
      int            edges_before;
      int            gap;

      for (int i = 0; i < NW; i++) ref_mem[i] = init_val(i);
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_vals();
      rst = 1'b0;
      #1;
      chk("ready_after_rst", 32'(bus.req_ready), 32'(1));

      // Single write then read-back of the same word.
      issue(1'b1, 5'h03, 8'hA5);
      issue(1'b0, 5'h03, 8'h00);
      idle(2);

      // Back-to-back writes at both address extremes, reads of both, then a held read request.
      issue(1'b1, 5'h00, 8'h11);
      issue(1'b1, 5'h1F, 8'hEE);
      issue(1'b0, 5'h00, 8'h00);
      issue(1'b0, 5'h1F, 8'h00);
      issue(1'b0, 5'h1F, 8'h00);
      drain();
      idle(2);

      // Reset during WSETUP of a write to 0x07 must abort it cleanly.
      saved        = ref_mem[7];
      edges_before = wr_edges;
      issue(1'b1, 5'h07, 8'h3C);
      rst = 1'b1;
      bus.req_valid = 1'b0;
      q.delete();
      ref_mem[7] = saved;
      last_rd    = '0;
      @(posedge clk); #1;
      check_reset_vals();
      rst = 1'b0;
      idle(6);
      chk("abort_no_write_edge", 32'(wr_edges), 32'(edges_before));
      chk("abort_word07", 32'(phys_mem[7]), 32'(saved));
      issue(1'b0, 5'h07, 8'h00);
      drain();

`ifdef MEM_SEQ_VERIFY_EN
      // Read path with bit 0 stuck low: 0x01 must mismatch, 0x02 must verify cleanly.
      stuck0 = 1'b1;
      issue(1'b1, 5'h0A, 8'h01);
      issue(1'b1, 5'h0B, 8'h02);
      drain();
      stuck0 = 1'b0;
`endif

      // Randomized traffic with random idle gaps (zero gap gives back-to-back requests).
      for (int n = 0; n < 80; n++) begin
         issue(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
         gap = int'($urandom_range(0, 2));
         idle(gap);
      end
      drain();
      idle(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_seq.md
MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 Parameter: AW, default 5, address width in bits (32-word memory).
REQ-002 Parameter: DW, default 8, data width in bits.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: req_valid  input  1  access request present.
REQ-006 Port: req_ready  output  1  sequencer can accept a request.
REQ-007 Port: req_we  input  1  1 = write, 0 = read.
REQ-008 Port: req_addr  input  AW  target word address.
REQ-009 Port: req_wdata  input  DW  write data.
REQ-010 Port: done  output  1  one-cycle pulse at access completion.
REQ-011 Port: rsp_rdata  output  DW  last read data, held until next read completes.
REQ-012 Port: vfy_err  output  1  write-verify mismatch pulse (see Configuration).
REQ-013 Port: mem_addr  output  AW  memory address.
REQ-014 Port: mem_data  inout  DW  bidirectional memory data bus.
REQ-015 Port: mem_read  output  1  memory read enable, active-high.
REQ-016 Port: mem_write  output  1  memory write strobe; memory captures on its rising edge.

Function
REQ-017 States SHALL be IDLE, WSETUP, WSTROBE, WHOLD, RSTROBE, RCAPT (plus VRD, VCAP when verify is enabled).
REQ-018 req_ready SHALL be 1 only in IDLE with rst low; a request is accepted on an edge where req_valid and req_ready are both 1.
REQ-019 On acceptance, req_we/req_addr/req_wdata SHALL be registered; mem_addr SHALL show the registered address from the next cycle until the access ends.
REQ-020 Write path: IDLE -> WSETUP -> WSTROBE -> WHOLD -> IDLE, one cycle each; mem_write SHALL be 1 only in WSTROBE.
REQ-021 The sequencer SHALL drive mem_data with the registered write data in WSETUP, WSTROBE and WHOLD only, and SHALL present high-impedance in every other state.
REQ-022 Read path: IDLE -> RSTROBE -> RCAPT -> IDLE; mem_read SHALL be 1 in RSTROBE and RCAPT; mem_data SHALL be sampled into rsp_rdata on the edge leaving RCAPT.
REQ-023 mem_read and the mem_data drive enable SHALL never both be 1 in the same cycle.
REQ-024 done SHALL pulse for exactly one cycle, in the IDLE cycle following the last access state; req_ready is 1 in that cycle, so back-to-back accesses are allowed.
REQ-025 Latency, acceptance edge to done high: write 3 cycles, read 2 cycles (write 5 with verify enabled).
REQ-026 rsp_rdata SHALL NOT change on writes or verify reads.
REQ-027 req_valid held while req_ready is 0 SHALL be ignored and SHALL NOT be queued.

Reset
REQ-028 rst high at a clock edge SHALL force IDLE, and set done=0, vfy_err=0, rsp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, with mem_data released to high-impedance.
REQ-029 rst asserted mid-access SHALL abort the access with no done pulse; a write aborted in WSETUP SHALL NOT produce a mem_write rising edge.
REQ-030 req_ready SHALL be 0 in any cycle where rst is 1.

Configuration
REQ-031 Macro MEM_SEQ_VERIFY_EN defined: after WHOLD, the sequencer SHALL enter VRD then VCAP (mem_read=1, bus released), compare the memory data with the written data, and return to IDLE; vfy_err SHALL pulse together with done on mismatch.
REQ-032 Macro MEM_SEQ_VERIFY_EN undefined: VRD and VCAP do not exist, WHOLD returns to IDLE, and vfy_err is constant 0.

Verification
REQ-033 Write addr 5'h03 data 8'hA5 -> mem_write high for exactly 1 cycle, bus = A5 in WSETUP..WHOLD, done high 3 cycles after acceptance.
REQ-034 Read back 5'h03 -> mem_read high for 2 cycles, bus never driven by the sequencer, rsp_rdata=8'hA5, done high 2 cycles after acceptance.
REQ-035 Back-to-back writes of 00/8'h11 and 1F/8'hEE, then reads of both -> no idle gap beyond the done cycle, reads return 11 and EE (address wrap to 1F is handled correctly).
REQ-036 rst pulsed during WSETUP of a write to 5'h07 -> no mem_write edge, word 07 unchanged, no done pulse, all outputs at reset values on the next cycle.
REQ-037 req_valid held high during a read -> exactly one access per acceptance, and the request is re-accepted only in the done/IDLE cycle.
REQ-038 MEM_SEQ_VERIFY_EN defined, memory model forced to return bit 0 stuck at 0, write 8'h01 -> vfy_err=1 with done after 5 cycles; write 8'h02 -> vfy_err=0.
